// File: rtl/ga21_pal_dma.sv
// Palette DMA engine: moves word blocks between a buffer RAM and palette RAM
// through the palram GA21 initiator port, programmed by four CPU registers.
module ga21_pal_dma #(
    parameter int unsigned BUF_AW = 16,
    parameter int unsigned PAL_AW = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vblank,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_reg,
    input  logic [15:0]       cpu_din,
    output logic [1:0]        status,
    output logic              buf_req,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [15:0]       buf_dout,
    input  logic [15:0]       buf_din,
    input  logic              buf_ack,
    output logic              dma_busy,
    output logic              ga21_req,
    output logic              ga21_we,
    output logic [PAL_AW-1:0] ga21_addr,
    output logic [15:0]       pal_dout,
    input  logic [15:0]       pal_din
);
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [3:0] {
        IDLE, WAITVB, BRD, PWR, PRD, PCAP, BWR, NEXT, DONE
    } state_t;

    state_t              state, state_nxt;
    logic [BUF_AW-1:0]   src_reg, src_reg_nxt, src_ptr, src_ptr_nxt;
    logic [PAL_AW-1:0]   dst_reg, dst_reg_nxt, dst_ptr, dst_ptr_nxt;
    logic [CNT_W-1:0]    cnt_reg, cnt_reg_nxt, rem, rem_nxt;
    logic [DATA_W-1:0]   data_reg, data_nxt;
    logic                dir, dir_nxt;
    logic                abort_pend, abort_pend_nxt;
    logic                done_flag, done_nxt;

    logic wr_ctrl, start, abort, idle;

    assign wr_ctrl = cpu_wr && (cpu_reg == 2'd3);
    assign start   = wr_ctrl && cpu_din[0];
    assign abort   = wr_ctrl && cpu_din[3];
    assign idle    = (state == IDLE);

    // Next-state, register-file and datapath update
    always_comb begin
        state_nxt      = state;
        src_reg_nxt    = src_reg;
        dst_reg_nxt    = dst_reg;
        cnt_reg_nxt    = cnt_reg;
        src_ptr_nxt    = src_ptr;
        dst_ptr_nxt    = dst_ptr;
        rem_nxt        = rem;
        data_nxt       = data_reg;
        dir_nxt        = dir;
        abort_pend_nxt = abort_pend;
        done_nxt       = done_flag;

        if (cpu_wr && idle) begin
            case (cpu_reg)
                2'd0:    src_reg_nxt = BUF_AW'(cpu_din);
                2'd1:    dst_reg_nxt = PAL_AW'(cpu_din[CNT_W-1:0]);
                2'd2:    cnt_reg_nxt = cpu_din[CNT_W-1:0];
                default: ;
            endcase
        end
        if (wr_ctrl) done_nxt = 1'b0;

        case (state)
            IDLE: begin
                abort_pend_nxt = 1'b0;
                if (start) begin
                    dir_nxt     = cpu_din[1];
                    src_ptr_nxt = src_reg;
                    dst_ptr_nxt = dst_reg;
                    rem_nxt     = cnt_reg;
                    if (cnt_reg == '0)     state_nxt = DONE;
                    else if (cpu_din[2])   state_nxt = WAITVB;
                    else if (cpu_din[1])   state_nxt = PRD;
                    else                   state_nxt = BRD;
                end
            end
            WAITVB: begin
                if (abort)       state_nxt = DONE;
                else if (vblank) state_nxt = dir ? PRD : BRD;
            end
            BRD, BWR: begin
                // An abort must let the outstanding buffer access complete
                if (abort) abort_pend_nxt = 1'b1;
                if (buf_ack) begin
                    if (state == BRD) data_nxt = buf_din;
                    if (abort || abort_pend) state_nxt = DONE;
                    else                     state_nxt = (state == BRD) ? PWR : NEXT;
                end
            end
            PWR:  state_nxt = abort ? DONE : NEXT;
            PRD:  state_nxt = abort ? DONE : PCAP;
            PCAP: begin
                data_nxt  = pal_din;
                state_nxt = abort ? DONE : BWR;
            end
            NEXT: begin
                src_ptr_nxt = src_ptr + BUF_AW'(1);
                dst_ptr_nxt = dst_ptr + PAL_AW'(1);
                rem_nxt     = rem - CNT_W'(1);
                if (abort || rem == CNT_W'(1)) state_nxt = DONE;
                else                           state_nxt = dir ? PRD : BRD;
            end
            DONE: begin
                state_nxt      = IDLE;
                done_nxt       = 1'b1;
                abort_pend_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the cycle being entered
    logic              buf_req_nxt, buf_we_nxt, ga21_req_nxt, ga21_we_nxt, busy_nxt;
    logic [BUF_AW-1:0] buf_addr_nxt;
    logic [PAL_AW-1:0] ga21_addr_nxt;
    logic [15:0]       buf_dout_nxt, pal_dout_nxt;

    always_comb begin
        busy_nxt      = (state_nxt != IDLE);
        buf_req_nxt   = (state_nxt == BRD) || (state_nxt == BWR);
        buf_we_nxt    = (state_nxt == BWR);
        ga21_req_nxt  = (state_nxt == PRD) || (state_nxt == PCAP) || (state_nxt == PWR);
        ga21_we_nxt   = (state_nxt == PWR);
        buf_addr_nxt  = buf_req_nxt ? src_ptr_nxt : '0;
        ga21_addr_nxt = ga21_req_nxt ? dst_ptr_nxt : '0;
        buf_dout_nxt  = buf_we_nxt ? data_nxt : '0;
        pal_dout_nxt  = ga21_we_nxt ? data_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            cnt_reg    <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            rem        <= '0;
            data_reg   <= '0;
            dir        <= 1'b0;
            abort_pend <= 1'b0;
            done_flag  <= 1'b0;
            status     <= '0;
            dma_busy   <= 1'b0;
            buf_req    <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_dout   <= '0;
            ga21_req   <= 1'b0;
            ga21_we    <= 1'b0;
            ga21_addr  <= '0;
            pal_dout   <= '0;
        end else begin
            state      <= state_nxt;
            src_reg    <= src_reg_nxt;
            dst_reg    <= dst_reg_nxt;
            cnt_reg    <= cnt_reg_nxt;
            src_ptr    <= src_ptr_nxt;
            dst_ptr    <= dst_ptr_nxt;
            rem        <= rem_nxt;
            data_reg   <= data_nxt;
            dir        <= dir_nxt;
            abort_pend <= abort_pend_nxt;
            done_flag  <= done_nxt;
            status     <= {done_nxt, busy_nxt};
            dma_busy   <= busy_nxt;
            buf_req    <= buf_req_nxt;
            buf_we     <= buf_we_nxt;
            buf_addr   <= buf_addr_nxt;
            buf_dout   <= buf_dout_nxt;
            ga21_req   <= ga21_req_nxt;
            ga21_we    <= ga21_we_nxt;
            ga21_addr  <= ga21_addr_nxt;
            pal_dout   <= pal_dout_nxt;
        end
    end

endmodule

// File: tb/tb_ga21_pal_dma.sv
// Scoreboarded bench for ga21_pal_dma with buffer-RAM responder and palram model.
module tb_ga21_pal_dma;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        vblank;
    logic        cpu_wr;
    logic [1:0]  cpu_reg;
    logic [15:0] cpu_din;
    logic [1:0]  status;
    logic        buf_req, buf_we;
    logic [15:0] buf_addr, buf_dout;
    logic [15:0] buf_din = '0;
    logic        buf_ack = 1'b0;
    logic        dma_busy, ga21_req, ga21_we;
    logic [12:0] ga21_addr;
    logic [15:0] pal_dout;
    logic [15:0] pal_din = '0;

    ga21_pal_dma #(.BUF_AW(16), .PAL_AW(13)) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank),
        .cpu_wr(cpu_wr), .cpu_reg(cpu_reg), .cpu_din(cpu_din), .status(status),
        .buf_req(buf_req), .buf_we(buf_we), .buf_addr(buf_addr), .buf_dout(buf_dout),
        .buf_din(buf_din), .buf_ack(buf_ack), .dma_busy(dma_busy),
        .ga21_req(ga21_req), .ga21_we(ga21_we), .ga21_addr(ga21_addr),
        .pal_dout(pal_dout), .pal_din(pal_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_pal;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  busy_cyc = 0, buf_req_cyc = 0, ga21_req_cyc = 0, pal_we_cyc = 0;
    int  lat = 1;

    logic        pre_we = 1'b0, pre_pal = 1'b0;
    logic [15:0] pre_addr = '0, pre_data = '0;
    logic [15:0] buf_mem [0:65535];
    logic [15:0] pal_mem [0:8191];
    int          ack_cnt = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic score(input logic is_pal, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got pal=%0d addr=%h data=%h, expected no write",
                     is_pal, addr, data);
        end else begin
            e = exp_q.pop_front();
            check(is_pal ? "pal_write" : "buf_write", 48'({is_pal, addr, data}), 48'(e));
        end
    endtask

    // Buffer RAM responder: buf_ack arrives lat cycles after buf_req rises
    always @(posedge clk) begin
        if (pre_we && !pre_pal) buf_mem[pre_addr] <= pre_data;
        if (!buf_req || buf_ack) begin
            ack_cnt <= 0;
            buf_ack <= 1'b0;
        end else if (ack_cnt == lat - 1) begin
            buf_ack <= 1'b1;
            buf_din <= buf_mem[buf_addr];
            if (buf_we) buf_mem[buf_addr] <= buf_dout;
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    // Palette RAM model with one-clock read latency
    always @(posedge clk) begin
        if (pre_we && pre_pal) pal_mem[pre_addr[12:0]] <= pre_data;
        else if (ga21_req && ga21_we) pal_mem[ga21_addr] <= pal_dout;
        pal_din <= pal_mem[ga21_addr];
    end

    // Monitor: scores every write the DUT presents and tallies activity
    always @(negedge clk) begin
        if (dma_busy) busy_cyc++;
        if (buf_req) buf_req_cyc++;
        if (ga21_req) begin
            ga21_req_cyc++;
            check("ga21_req_implies_dma_busy", 48'(dma_busy), 48'(1));
        end
        if (ga21_req && ga21_we) begin
            pal_we_cyc++;
            score(1'b1, 16'(ga21_addr), pal_dout);
        end
        if (buf_req && buf_we && buf_ack) score(1'b0, buf_addr, buf_dout);
    end

    task automatic wr(input logic [1:0] r, input logic [15:0] d);
        @(negedge clk);
        cpu_wr = 1'b1; cpu_reg = r; cpu_din = d;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_reg = '0; cpu_din = '0;
    endtask

    task automatic preload(input logic is_pal, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_pal = is_pal; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic push(input logic is_pal, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.is_pal = is_pal; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (dma_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dma_busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy after %0d cycles, expected idle", budget);
        end
    endtask

    initial begin
        int b0, r0, g0, w0, n;
        reset_n = 1'b0; vblank = 1'b0; cpu_wr = 1'b0; cpu_reg = '0; cpu_din = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 48'({status, buf_req, dma_busy, ga21_req, ga21_we}), 48'(0));
        reset_n = 1'b1;

        // Buffer -> palette, ack latency 2
        for (int i = 0; i < 4; i++) preload(1'b0, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
        lat = 2;
        wr(2'd0, 16'h0100); wr(2'd1, 16'h0010); wr(2'd2, 16'd4);
        for (int i = 0; i < 4; i++) push(1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
        check("b2p_status_before", 48'(status), 48'(2'b00));
        b0 = busy_cyc; w0 = pal_we_cyc;
        wr(2'd3, 16'h0001);
        check("b2p_busy_after_start", 48'({dma_busy, status}), 48'(3'b101));
        wait_idle(500);
        check("b2p_busy_cycles", 48'(busy_cyc - b0), 48'(21));
        check("b2p_we_pulses", 48'(pal_we_cyc - w0), 48'(4));
        check("b2p_status_after", 48'(status), 48'(2'b10));
        check("b2p_drained", 48'(exp_q.size()), 48'(0));

        // Palette -> buffer with palette address wrap, ack latency 1
        preload(1'b1, 16'h1FFE, 16'h1234);
        preload(1'b1, 16'h1FFF, 16'h5678);
        preload(1'b1, 16'h0000, 16'h9ABC);
        lat = 1;
        wr(2'd0, 16'h0200); wr(2'd1, 16'h1FFE); wr(2'd2, 16'd3);
        push(1'b0, 16'h0200, 16'h1234);
        push(1'b0, 16'h0201, 16'h5678);
        push(1'b0, 16'h0202, 16'h9ABC);
        b0 = busy_cyc; w0 = pal_we_cyc;
        wr(2'd3, 16'h0003);
        wait_idle(500);
        check("p2b_busy_cycles", 48'(busy_cyc - b0), 48'(16));
        check("p2b_no_pal_we", 48'(pal_we_cyc - w0), 48'(0));
        check("p2b_drained", 48'(exp_q.size()), 48'(0));

        // Zero-length start
        wr(2'd2, 16'd0);
        b0 = busy_cyc; r0 = buf_req_cyc; g0 = ga21_req_cyc;
        wr(2'd3, 16'h0001);
        check("cnt0_done_state", 48'(status), 48'(2'b01));
        @(negedge clk);
        check("cnt0_status_after", 48'(status), 48'(2'b10));
        check("cnt0_busy_cycles", 48'(busy_cyc - b0), 48'(1));
        check("cnt0_no_requests", 48'((buf_req_cyc - r0) + (ga21_req_cyc - g0)), 48'(0));

        // Start gated on vblank
        preload(1'b0, 16'h0300, 16'hB000);
        preload(1'b0, 16'h0301, 16'hB001);
        wr(2'd0, 16'h0300); wr(2'd1, 16'h0100); wr(2'd2, 16'd2);
        push(1'b1, 16'h0100, 16'hB000);
        push(1'b1, 16'h0101, 16'hB001);
        r0 = buf_req_cyc;
        wr(2'd3, 16'h0005);
        for (int i = 0; i < 50; i++) @(negedge clk);
        check("vb_no_req_while_low", 48'(buf_req_cyc - r0), 48'(0));
        vblank = 1'b1;
        @(negedge clk);
        check("vb_req_after_rise", 48'(buf_req), 48'(1));
        wait_idle(500);
        vblank = 1'b0;
        check("vb_drained", 48'(exp_q.size()), 48'(0));

        // Abort while a buffer read is outstanding
        preload(1'b0, 16'h0400, 16'hC000);
        lat = 6;
        wr(2'd0, 16'h0400); wr(2'd1, 16'h0200); wr(2'd2, 16'd3);
        b0 = busy_cyc; r0 = buf_req_cyc; w0 = pal_we_cyc;
        wr(2'd3, 16'h0001);
        wr(2'd3, 16'h0008);
        check("abort_req_held", 48'({buf_req, status}), 48'(3'b101));
        wait_idle(500);
        check("abort_req_cycles", 48'(buf_req_cyc - r0), 48'(7));
        check("abort_busy_cycles", 48'(busy_cyc - b0), 48'(8));
        check("abort_no_pal_we", 48'(pal_we_cyc - w0), 48'(0));
        check("abort_status", 48'(status), 48'(2'b10));

        // Reset during PWR, then restart and ignored writes while busy
        for (int i = 0; i < 4; i++) preload(1'b0, 16'h0500 + 16'(i), 16'hD000 + 16'(i));
        lat = 1;
        wr(2'd0, 16'h0500); wr(2'd1, 16'h0300); wr(2'd2, 16'd4);
        push(1'b1, 16'h0300, 16'hD000);
        wr(2'd3, 16'h0001);
        n = 0;
        while (!ga21_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_pwr", 48'(ga21_we), 48'(1));
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_outputs_zero",
              48'({status, buf_req, buf_we, buf_addr, dma_busy, ga21_req, ga21_we, ga21_addr}),
              48'(0));
        check("rst_data_zero", 48'({buf_dout, pal_dout}), 48'(0));
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_quiet", 48'({buf_req, ga21_req, exp_q.size() == 0}), 48'(1));

        preload(1'b0, 16'h0600, 16'hE000);
        preload(1'b0, 16'h0601, 16'hE001);
        lat = 3;
        wr(2'd0, 16'h0600); wr(2'd1, 16'h0400); wr(2'd2, 16'd2);
        push(1'b1, 16'h0400, 16'hE000);
        push(1'b1, 16'h0401, 16'hE001);
        wr(2'd3, 16'h0001);
        wr(2'd0, 16'h0700); wr(2'd1, 16'h0500); wr(2'd2, 16'd7);
        check("busy_during_reg_writes", 48'(dma_busy), 48'(1));
        wait_idle(500);
        check("restart_drained", 48'(exp_q.size()), 48'(0));
        push(1'b1, 16'h0400, 16'hE000);
        push(1'b1, 16'h0401, 16'hE001);
        b0 = busy_cyc;
        wr(2'd3, 16'h0001);
        wait_idle(500);
        check("rerun_busy_cycles", 48'(busy_cyc - b0), 48'(13));
        check("rerun_drained", 48'(exp_q.size()), 48'(0));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

endmodule
